pipelined_adder: RTL

Parametrised, pipelined successor to the single-cycle 64-bit adder. It splits a WIDTH-bit add/subtract into STAGES equal segments, one segment per pipeline stage, and registers the carry between stages. Throughput is one operation per clock. Input and output use valid/ready handshakes, so the block can sit between the ALU operand latch and the writeback register with backpressure. It adds a subtract mode and a signed-overflow flag, which the single-cycle adder does not have.

---
 rtl/pipelined_adder_if.sv | 32 +++
 rtl/pipelined_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Purpose: request/response bundle for pipelined_adder (operands in, sum out).
// Latency: n/a, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the response side.
// Ports (via modports):
//   slave  - the adder: takes in_valid/operand1/operand2/cin/sub/out_ready,
//            drives in_ready/out_valid/result/cout/overflow.
//   master - the producer/consumer pair facing the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, operand1, operand2, cin, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow
  );

  modport slave (
    input  in_valid, operand1, operand2, cin, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Purpose: WIDTH-bit add/subtract split into STAGES segments, carry registered between stages.
// Latency: STAGES register stages; an op accepted at edge N is visible after edge N+STAGES-1.
// Backpressure: per-stage valid/ready chain; a full stage holds while the next stage is stalled,
//               empty stages load regardless, so bubbles collapse.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset, clears every stage
//   bus    - slave side of pipelined_adder_if (request handshake + operands, response handshake + flags)
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  pipelined_adder_if.slave  bus
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // rdy[k] means stage k may load this cycle; rdy[STAGES] is the consumer.
  logic [STAGES:0] rdy;

  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be processed when entering stage k. The current
    // segment always sits at the bottom, the global MSB always at the top.
    localparam int RIN = WIDTH - k * SEG;

    logic [RIN-1:0]         a_in;
    logic [RIN-1:0]         b_in;
    logic                   c_in;
    logic                   v_in;
    logic [SEG:0]           seg_sum;
    logic [(k+1)*SEG-1:0]   sum_d;
    logic [(k+1)*SEG-1:0]   sum_q;
    logic                   cy_q;
    logic                   vld_q;
    logic                   load;

    if (k == 0) begin : g_first
      // Subtract is a + ~b + ~borrow_in, so invert both operand2 and cin.
      assign a_in  = bus.operand1;
      assign b_in  = bus.sub ? ~bus.operand2 : bus.operand2;
      assign c_in  = bus.sub ^ bus.cin;
      assign v_in  = bus.in_valid;
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_mid
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign c_in  = g_stage[k-1].cy_q;
      assign v_in  = g_stage[k-1].vld_q;
      assign sum_d = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    assign rdy[k] = !vld_q || rdy[k+1];
    // Data registers only move when a real op arrives, so an idle or
    // stalled stage keeps its contents bit-for-bit.
    assign load   = rdy[k] && v_in;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_q <= 1'b0;
      end else if (rdy[k]) begin
        vld_q <= v_in;
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sum_q <= '0;
        cy_q  <= 1'b0;
      end else if (load) begin
        sum_q <= sum_d;
        cy_q  <= seg_sum[SEG];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Forward only the operand bits later stages still need.
      logic [RIN-SEG-1:0] a_q;
      logic [RIN-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          a_q <= '0;
          b_q <= '0;
        end else if (load) begin
          a_q <= a_in[RIN-1:SEG];
          b_q <= b_in[RIN-1:SEG];
        end
      end
    end else begin : g_last
      // Signed overflow: operands agree in sign (b already inverted for
      // subtract) but the result sign differs.
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_in[RIN-1] == b_in[RIN-1]) && (seg_sum[SEG-1] != a_in[RIN-1]);

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.result    = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].cy_q;
  assign bus.overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule
